// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause and EPC,
// exception/eret state updates, timer interrupt and the interrupt-pending request.
module cp0_regfile #(
  parameter logic [4:0] NO_EX     = 5'h1f,
  parameter int         COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ex_code,
  input  logic        bd,
  input  logic        eret,
  input  logic [31:0] badvaddr,
  input  logic        pc_error,
  input  logic        mtc0,
  input  logic [4:0]  mtc0_waddr,
  input  logic [31:0] mtc0_wdata,
  input  logic [5:0]  ext_int,
  output logic [31:0] cause,
  output logic [31:0] status,
  output logic        int_pending
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] badvaddr_q, count_q, compare_q, epc_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q, bd_q, ti_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exc_code_q;
  logic        tick_q, compare_wr_q, int_pending_q;

  logic [31:0] badvaddr_nxt, count_nxt, compare_nxt, epc_nxt;
  logic [7:0]  im_nxt;
  logic        exl_nxt, ie_nxt, bd_nxt, ti_nxt;
  logic [5:0]  ip_hw_nxt;
  logic [1:0]  ip_sw_nxt;
  logic [4:0]  exc_code_nxt;
  logic        tick_nxt, compare_wr_nxt, int_pending_nxt;

  logic ex_commit, count_inc, timer_hit;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  // NOTE: every register's next value is built in one always_comb with a default
  // first, so no latches form and int_pending can be derived from post-edge state.
  always_comb begin
    ex_commit  = (ex_code != NO_EX);
    wr_count   = mtc0 && (mtc0_waddr == REG_COUNT);
    wr_compare = mtc0 && (mtc0_waddr == REG_COMPARE);
    wr_status  = mtc0 && (mtc0_waddr == REG_STATUS);
    wr_cause   = mtc0 && (mtc0_waddr == REG_CAUSE);
    wr_epc     = mtc0 && (mtc0_waddr == REG_EPC);

    // Divider keeps running even when Count is overwritten.
    count_inc = (COUNT_DIV == 1) || tick_q;
    tick_nxt  = (COUNT_DIV == 1) ? 1'b0 : ~tick_q;
    count_nxt = wr_count ? mtc0_wdata : (count_inc ? count_q + 32'd1 : count_q);

    compare_nxt    = wr_compare ? mtc0_wdata : compare_q;
    compare_wr_nxt = compare_wr_q | wr_compare;
    timer_hit      = (count_q == compare_q) && ((count_q != 32'd0) || compare_wr_q);
    ti_nxt         = wr_compare ? 1'b0 : (timer_hit ? 1'b1 : ti_q);

    ip_hw_nxt = {ext_int[5] | ti_nxt, ext_int[4:0]};
    ip_sw_nxt = wr_cause ? mtc0_wdata[9:8] : ip_sw_q;

    im_nxt = wr_status ? mtc0_wdata[15:8] : im_q;
    ie_nxt = wr_status ? mtc0_wdata[0] : ie_q;
    exl_nxt = exl_q;
    if (ex_commit)      exl_nxt = 1'b1;
    else if (eret)      exl_nxt = 1'b0;
    else if (wr_status) exl_nxt = mtc0_wdata[1];

    // A nested exception (EXL already set) keeps the original EPC and BD.
    epc_nxt = epc_q;
    if (ex_commit && !exl_q && (waddr == REG_EPC)) epc_nxt = bd ? wdata - 32'd4 : wdata;
    else if (wr_epc)                               epc_nxt = mtc0_wdata;

    bd_nxt       = (ex_commit && !exl_q) ? bd : bd_q;
    exc_code_nxt = ex_commit ? ex_code : exc_code_q;

    badvaddr_nxt = badvaddr_q;
    if (ex_commit && (pc_error || ex_code == 5'd4 || ex_code == 5'd5))
      badvaddr_nxt = pc_error ? wdata : badvaddr;

    int_pending_nxt = ie_nxt & ~exl_nxt & (|({ip_hw_nxt, ip_sw_nxt} & im_nxt));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q    <= '0;
      count_q       <= '0;
      compare_q     <= '0;
      epc_q         <= '0;
      im_q          <= '0;
      exl_q         <= 1'b0;
      ie_q          <= 1'b0;
      bd_q          <= 1'b0;
      ti_q          <= 1'b0;
      ip_hw_q       <= '0;
      ip_sw_q       <= '0;
      exc_code_q    <= '0;
      tick_q        <= 1'b0;
      compare_wr_q  <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      badvaddr_q    <= badvaddr_nxt;
      count_q       <= count_nxt;
      compare_q     <= compare_nxt;
      epc_q         <= epc_nxt;
      im_q          <= im_nxt;
      exl_q         <= exl_nxt;
      ie_q          <= ie_nxt;
      bd_q          <= bd_nxt;
      ti_q          <= ti_nxt;
      ip_hw_q       <= ip_hw_nxt;
      ip_sw_q       <= ip_sw_nxt;
      exc_code_q    <= exc_code_nxt;
      tick_q        <= tick_nxt;
      compare_wr_q  <= compare_wr_nxt;
      int_pending_q <= int_pending_nxt;
    end
  end

  assign status      = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause       = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b0};
  assign int_pending = int_pending_q;

  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_STATUS:   rdata = status;
      REG_CAUSE:    rdata = cause;
      REG_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset state, timer, exceptions, eret, mtc0
// priority, Count wrap (COUNT_DIV=1 instance) and asynchronous mid-run reset.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  raddr, waddr, ex_code, mtc0_waddr;
  logic [31:0] wdata, badvaddr, mtc0_wdata;
  logic        bd, eret, pc_error, mtc0;
  logic [5:0]  ext_int;
  logic [31:0] rdata, cause, status;
  logic        int_pending;
  logic [31:0] rdata1, cause1, status1;
  logic        int_pending1;

  int checks = 0;
  int errors = 0;
  logic found;

  always #5 clk = ~clk;

  cp0_regfile #(.NO_EX(5'h1f), .COUNT_DIV(2)) u_dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .waddr(waddr),
    .wdata(wdata), .ex_code(ex_code), .bd(bd), .eret(eret), .badvaddr(badvaddr),
    .pc_error(pc_error), .mtc0(mtc0), .mtc0_waddr(mtc0_waddr), .mtc0_wdata(mtc0_wdata),
    .ext_int(ext_int), .cause(cause), .status(status), .int_pending(int_pending)
  );

  cp0_regfile #(.NO_EX(5'h1f), .COUNT_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata1), .waddr(waddr),
    .wdata(wdata), .ex_code(ex_code), .bd(bd), .eret(eret), .badvaddr(badvaddr),
    .pc_error(pc_error), .mtc0(mtc0), .mtc0_waddr(mtc0_waddr), .mtc0_wdata(mtc0_wdata),
    .ext_int(ext_int), .cause(cause1), .status(status1), .int_pending(int_pending1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic idle_inputs();
    waddr = 5'h1f; wdata = '0; ex_code = 5'h1f; bd = 1'b0; eret = 1'b0;
    badvaddr = '0; pc_error = 1'b0; mtc0 = 1'b0; mtc0_waddr = '0; mtc0_wdata = '0;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1; mtc0_waddr = a; mtc0_wdata = d;
    tick();
    mtc0 = 1'b0;
  endtask

  task automatic do_ex(input logic [4:0] code, input logic [31:0] w, input logic b,
                       input logic pce, input logic [31:0] bva);
    ex_code = code; waddr = 5'd14; wdata = w; bd = b; pc_error = pce; badvaddr = bva;
    tick();
    idle_inputs();
  endtask

  initial begin
    resetn = 1'b0;
    raddr = 5'h1f;
    ext_int = '0;
    idle_inputs();
    #3;
    rd_chk("rst_badvaddr", 5'd8, 32'h0);
    rd_chk("rst_count", 5'd9, 32'h0);
    rd_chk("rst_compare", 5'd11, 32'h0);
    rd_chk("rst_status", 5'd12, 32'h0040_0000);
    rd_chk("rst_cause", 5'd13, 32'h0);
    rd_chk("rst_epc", 5'd14, 32'h0);
    check("rst_int_pending", {31'b0, int_pending}, 32'h0);

    @(negedge clk) resetn = 1'b1;
    tick();
    check("post_rst_status", status, 32'h0040_0000);
    check("post_rst_cause", cause, 32'h0);
    rd_chk("unimpl_1f", 5'h1f, 32'h0);
    rd_chk("unimpl_10", 5'd10, 32'h0);

    // Timer: Compare=10, Count=0, two cycles per increment.
    do_mtc0(5'd11, 32'd10);
    do_mtc0(5'd9, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (cause[30]) found = 1'b1;
    end
    check("timer_ti_seen", {31'b0, found}, 32'h1);
    check("timer_ip7", {31'b0, cause[15]}, 32'h1);
    raddr = 5'd9;
    #1;
    check("timer_count_at_ti", {31'b0, (rdata == 32'd10) || (rdata == 32'd11)}, 32'h1);

    do_mtc0(5'd12, 32'h0000_8001);
    check("im7_status", status, 32'h0040_8001);
    check("im7_int_pending", {31'b0, int_pending}, 32'h1);

    do_mtc0(5'd11, 32'd10);
    check("cmp_clear_ti", {30'b0, cause[30], cause[15]}, 32'h0);
    check("cmp_clear_int_pending", {31'b0, int_pending}, 32'h0);

    // Instruction-fetch address error.
    do_ex(5'h04, 32'hbfc0_0003, 1'b0, 1'b1, 32'h0);
    rd_chk("adel_epc", 5'd14, 32'hbfc0_0003);
    rd_chk("adel_badvaddr", 5'd8, 32'hbfc0_0003);
    check("adel_cause", cause, 32'h0000_0010);
    check("adel_status", status, 32'h0040_8003);
    check("adel_int_pending", {31'b0, int_pending}, 32'h0);

    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("eret_status", status, 32'h0040_8001);

    // Exception in a delay slot, then a nested one with EXL set.
    do_ex(5'h08, 32'h8000_0104, 1'b1, 1'b0, 32'h1234_5678);
    rd_chk("bd_epc", 5'd14, 32'h8000_0100);
    rd_chk("bd_badvaddr_kept", 5'd8, 32'hbfc0_0003);
    check("bd_cause", cause, 32'h8000_0020);

    do_ex(5'h05, 32'h8000_0200, 1'b0, 1'b0, 32'hdead_0000);
    rd_chk("nested_epc", 5'd14, 32'h8000_0100);
    rd_chk("nested_badvaddr", 5'd8, 32'hdead_0000);
    check("nested_cause", cause, 32'h8000_0014);

    do_mtc0(5'd8, 32'h1111_1111);
    rd_chk("ro_badvaddr", 5'd8, 32'hdead_0000);

    eret = 1'b1;
    mtc0 = 1'b1; mtc0_waddr = 5'd12; mtc0_wdata = 32'h0000_0003;
    tick();
    eret = 1'b0; mtc0 = 1'b0;
    check("eret_vs_mtc0_status", status, 32'h0040_0001);

    // External interrupt line 0 -> Cause.IP2, masked by IM2.
    ext_int = 6'b000001;
    tick();
    check("ext_ip2_cause", cause, 32'h8000_0414);
    do_mtc0(5'd12, 32'h0000_0401);
    check("ext_int_pending", {31'b0, int_pending}, 32'h1);
    ext_int = '0;
    tick();
    check("ext_drop_int_pending", {31'b0, int_pending}, 32'h0);

    // Exception and mtc0 Count in the same cycle: both land.
    ex_code = 5'h0c; waddr = 5'd14; wdata = 32'h8000_0300;
    mtc0 = 1'b1; mtc0_waddr = 5'd9; mtc0_wdata = 32'h0000_0100;
    tick();
    idle_inputs();
    rd_chk("ex_mtc0_count", 5'd9, 32'h0000_0100);
    rd_chk("ex_mtc0_epc", 5'd14, 32'h8000_0300);
    check("ex_mtc0_status", status, 32'h0040_0403);
    check("ex_mtc0_cause", cause, 32'h0000_0030);

    // Count wrap on the COUNT_DIV=1 instance.
    do_mtc0(5'd9, 32'hffff_fffe);
    raddr = 5'd9;
    #1;
    check("wrap_fffffffe", rdata1, 32'hffff_fffe);
    tick();
    check("wrap_ffffffff", rdata1, 32'hffff_ffff);
    tick();
    check("wrap_zero", rdata1, 32'h0);

    // Asynchronous reset in the middle of a cycle.
    resetn = 1'b0;
    #1;
    check("midrst_status", status, 32'h0040_0000);
    check("midrst_cause", cause, 32'h0);
    check("midrst_int_pending", {31'b0, int_pending}, 32'h0);
    rd_chk("midrst_epc", 5'd14, 32'h0);
    rd_chk("midrst_badvaddr", 5'd8, 32'h0);
    rd_chk("midrst_compare", 5'd11, 32'h0);
    raddr = 5'd9;
    #1;
    check("midrst_count_div1", rdata1, 32'h0);
    check("midrst_count_div2", rdata, 32'h0);
    tick();
    @(negedge clk) resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file and exception-state responder for the 5-stage MIPS core.
- Serves the CP0 read, write and control requests that the writeback stage issues: mfc0 reads, mtc0 writes, exception commit and eret.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Generates the timer interrupt and the interrupt-pending request back to the pipeline.

Parameters:
- NO_EX, 5'h1f, ex_code value meaning "no exception this cycle".
- COUNT_DIV, 2, clock cycles per Count increment; legal values 1 or 2.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- raddr  in  5  CP0 register number to read; 5'h1f means no read.
- rdata  out  32  read data, combinational from raddr.
- waddr  in  5  exception-commit target; 14 (EPC) when an exception commits, else 5'h1f.
- wdata  in  32  faulting PC, or faulting address when pc_error=1.
- ex_code  in  5  committed exception code; NO_EX when none.
- bd  in  1  faulting instruction is in a branch delay slot.
- eret  in  1  eret commits this cycle.
- badvaddr  in  32  faulting virtual address.
- pc_error  in  1  fault is an instruction-fetch address error.
- mtc0  in  1  mtc0 write strobe.
- mtc0_waddr  in  5  mtc0 register number.
- mtc0_wdata  in  32  mtc0 data.
- ext_int  in  6  external hardware interrupt lines, level-sensitive.
- cause  out  32  current Cause register.
- status  out  32  current Status register.
- int_pending  out  1  interrupt should be taken.

Behaviour:
- Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
- Reads of any other number, including 5'h1f, return 0.
- Reads are combinational.
- A read in the same cycle as a write returns the pre-write value.
- Reset values, applied asynchronously on resetn low:
  - Status = 32'h0040_0000 (BEV = 1).
  - All other registers = 0.
  - Internal tick divider = 0; int_pending = 0.
- Status field rules:
  - BEV (bit 22) is hardwired to 1.
  - IM[7:0] (bits 15:8), EXL (bit 1) and IE (bit 0) are writable.
  - All other Status bits read 0.
- Cause field rules:
  - BD = bit 31, TI = bit 30, IP[7:2] = bits 15:10, IP[1:0] = bits 9:8, ExcCode = bits 6:2.
  - Only IP[1:0] is mtc0-writable.
  - IP[7:2] is loaded every cycle from {ext_int[5] | TI, ext_int[4:0]}.
- Count:
  - Increments by 1 once every COUNT_DIV cycles and wraps 32'hffff_ffff -> 0.
  - An mtc0 to Count loads mtc0_wdata and suppresses that cycle's increment; the divider phase is not reset.
- Timer:
  - TI sets on the cycle after Count == Compare, with Count != 0 or Compare written.
  - An mtc0 to Compare loads the value and clears TI in the same edge; a clear wins over a set.
- Exception commit (ex_code != NO_EX):
  - If Status.EXL == 0:
    - EPC <= bd ? wdata - 4 : wdata.
    - Cause.BD <= bd.
  - Regardless of EXL:
    - Cause.ExcCode <= ex_code.
    - Status.EXL <= 1.
  - If pc_error = 1 or ex_code is 4 or 5, BadVAddr <= (pc_error ? wdata : badvaddr).
  - Take EPC from wdata only when waddr == 14; otherwise leave EPC unchanged.
- eret: Status.EXL <= 0.
- Same-cycle priority: exception > eret > mtc0.
  - A lower-priority event is dropped only for fields the higher one writes.
  - An mtc0 to Count or Compare still lands alongside an exception.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
  - Registered: it reflects register state after the edge.
- Writes to read-only or unimplemented numbers are ignored.
- Reset mid-operation returns every register to its reset value within the same cycle; no partial updates.

Test Plan:
- Release reset, read each register via raddr -> Status = 32'h0040_0000, all others 0; int_pending = 0.
- mtc0 Compare = 10, Count = 0, COUNT_DIV = 2 -> TI = 1 about 20 cycles later; Cause bit 15 = 1.
  - Then mtc0 Status = 32'h0000_8001 -> int_pending = 1.
  - Then mtc0 Compare = 10 again -> TI and int_pending clear next cycle.
- ex_code = 5'h04, pc_error = 1, wdata = 32'hbfc0_0003, bd = 0, waddr = 14 -> EPC = 32'hbfc0_0003, BadVAddr = 32'hbfc0_0003, Cause[6:2] = 4, EXL = 1.
- ex_code = 5'h08, bd = 1, wdata = 32'h8000_0104, EXL = 0 -> EPC = 32'h8000_0100, Cause.BD = 1.
  - Then a second exception with EXL = 1 -> EPC unchanged, ExcCode updated.
- eret together with mtc0 Status = 32'h0000_0003 -> EXL = 0 (eret wins on EXL), IE = 1.
- Set Count = 32'hffff_fffe, COUNT_DIV = 1 -> reads fffffffe, ffffffff, 0.
  - Assert resetn low mid-sequence -> all registers return to reset values immediately.
